// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  localparam logic [6:0] I2C_TGT_DEFAULT_ADDR = 7'b1101101;

endpackage

// File: rtl/i2c_bus_sync.sv
// scl/sda input synchroniser with edge, START and STOP detection.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl_s;
  logic                   scl_q;
  logic                   sda_q;

  // Reset to the idle-bus level so leaving reset never fakes an edge on a quiet bus
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda};
      scl_q  <= scl_s;
      sda_q  <= sda_s;
    end
  end

  assign scl_s     = scl_sr[SYNC_STAGES-1];
  assign sda_s     = sda_sr[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C register-file target: address match, pointer-then-data writes, burst reads.
// Define I2C_TGT_GENERAL_CALL_EN to ACK and discard general-call (7'h00, write) traffic.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = I2C_TGT_DEFAULT_ADDR,
  parameter int unsigned NREGS       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl,
  inout  wire                      sda,
  input  logic [$clog2(NREGS)-1:0] loc_addr,
  output logic [7:0]               loc_data,
  output logic                     wr_strobe,
  output logic [$clog2(NREGS)-1:0] wr_index,
  output logic [7:0]               wr_value,
  output logic                     busy
);

  localparam int unsigned PW = $clog2(NREGS);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
`ifdef I2C_TGT_GENERAL_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_t state, state_d;
  logic [3:0]     cnt, cnt_d;
  logic [7:0]     shreg, shreg_d;
  logic [PW-1:0]  ptr, ptr_d;
  logic           sda_oe, sda_oe_d;
  logic           busy_d;
  logic           gc, gc_d;
  logic           wr_en;
  logic [7:0]     regs [NREGS];
  logic [7:0]     rx_byte;
  logic [7:0]     rd_cur, rd_next;
  logic [2:0]     bit_idx;
  logic           gc_hit, addr_hit;

  assign rx_byte  = {shreg[6:0], sda_s};
  assign gc_hit   = GC_EN && (shreg == 8'h00);
  assign addr_hit = (shreg[7:1] == TARGET_ADDR) || gc_hit;
  assign rd_cur   = regs[ptr];
  assign rd_next  = regs[ptr + PTR_ONE];
  assign bit_idx  = 3'd7 - cnt[2:0];
  assign loc_data = regs[loc_addr];
  assign sda      = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Receive states advance on the scl fall after the 8th bit so the ACK is driven while scl is low
  always_comb begin
    state_d = state;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_ADDR;
    end else begin
      case (state)
        ST_ADDR:     if (scl_fall && cnt[3]) state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK: if (scl_fall) state_d = (shreg[0] == I2C_RW_READ) ? ST_RD_DATA : ST_PTR;
        ST_PTR:      if (scl_fall && cnt[3]) state_d = ST_PTR_ACK;
        ST_PTR_ACK:  if (scl_fall) state_d = ST_WR_DATA;
        ST_WR_DATA:  if (scl_fall && cnt[3]) state_d = ST_WR_ACK;
        ST_WR_ACK:   if (scl_fall) state_d = ST_WR_DATA;
        ST_RD_DATA:  if (scl_fall && cnt[3]) state_d = ST_RD_ACK;
        ST_RD_ACK: begin
          if (scl_rise && sda_s == I2C_NACK) state_d = ST_IGNORE;
          else if (scl_fall)                 state_d = ST_RD_DATA;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt;
    shreg_d  = shreg;
    ptr_d    = ptr;
    sda_oe_d = sda_oe;
    busy_d   = busy;
    gc_d     = gc;
    wr_en    = 1'b0;
    if (stop_det) begin
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      gc_d     = 1'b0;
    end else if (start_det) begin
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      gc_d     = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          if (scl_rise && !cnt[3]) begin
            shreg_d = rx_byte;
            cnt_d   = cnt + 4'd1;
            if (cnt == 4'd7 && !gc) begin
              if (state == ST_PTR)     ptr_d = rx_byte[PW-1:0];
              if (state == ST_WR_DATA) wr_en = 1'b1;
            end
          end
          if (scl_fall && cnt[3]) begin
            cnt_d = '0;
            if (state != ST_ADDR) begin
              sda_oe_d = 1'b1;
            end else if (addr_hit) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              gc_d     = gc_hit;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (shreg[0] == I2C_RW_READ) begin
              shreg_d  = rd_cur;
              sda_oe_d = ~rd_cur[7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_PTR_ACK: if (scl_fall) sda_oe_d = 1'b0;
        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (!gc) ptr_d = ptr + PTR_ONE;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise && !cnt[3]) cnt_d = cnt + 4'd1;
          if (scl_fall) begin
            if (cnt[3]) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
            end else begin
              sda_oe_d = ~shreg[bit_idx];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_fall) begin
            ptr_d    = ptr + PTR_ONE;
            shreg_d  = rd_next;
            sda_oe_d = ~rd_next[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      shreg     <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      gc        <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      wr_value  <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      cnt       <= cnt_d;
      shreg     <= shreg_d;
      ptr       <= ptr_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
      gc        <= gc_d;
      wr_strobe <= wr_en;
      if (wr_en) begin
        regs[ptr] <= rx_byte;
        wr_index  <= ptr;
        wr_value  <= rx_byte;
      end
    end
  end

endmodule
